// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                                |
// | Brief    : Frame-sampled 2-digit multiplexed 7-segment driver (00..15).    |
// |            Optional build macro: LEADING_ZERO_BLANK_EN (blank tens = 0).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int                 c_psc_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(REFRESH_DIV - 1);
  localparam logic [6:0]         c_seg_inv  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]         c_an_inv   = (AN_ACT_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ONES = 2'd1,
    S_TENS = 2'd2
  } state_t;

  // r_state names the phase whose outputs are registered on the next edge,
  // so the first edge after reset release presents the LOAD cycle.
  state_t             r_state, w_state_nxt;
  logic [c_psc_w-1:0] r_psc, w_psc_nxt;
  logic [3:0]         r_snap;
  logic [6:0]         r_seg, w_seg_nxt;
  logic [1:0]         r_an, w_an_nxt;
  logic               r_fd, w_fd_nxt;
  logic               w_tens;
  logic [3:0]         w_ones;

  function automatic logic [6:0] f_seg_code(input logic [3:0] d);
    case (d)
      4'd0:    f_seg_code = 7'h3F;
      4'd1:    f_seg_code = 7'h06;
      4'd2:    f_seg_code = 7'h5B;
      4'd3:    f_seg_code = 7'h4F;
      4'd4:    f_seg_code = 7'h66;
      4'd5:    f_seg_code = 7'h6D;
      4'd6:    f_seg_code = 7'h7D;
      4'd7:    f_seg_code = 7'h07;
      4'd8:    f_seg_code = 7'h7F;
      4'd9:    f_seg_code = 7'h6F;
      default: f_seg_code = 7'h00;
    endcase
  endfunction

  assign w_tens = (r_snap >= 4'd10);
  assign w_ones = w_tens ? (r_snap - 4'd10) : r_snap;

  always_comb begin
    w_state_nxt = r_state;
    w_psc_nxt   = '0;
    w_seg_nxt   = c_seg_inv;
    w_an_nxt    = c_an_inv;
    w_fd_nxt    = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_fd_nxt    = 1'b1;
        w_state_nxt = S_ONES;
      end
      S_ONES: begin
        w_seg_nxt = f_seg_code(w_ones) ^ c_seg_inv;
        w_an_nxt  = 2'b01 ^ c_an_inv;
        if (r_psc == c_psc_last) w_state_nxt = S_TENS;
        else                     w_psc_nxt   = r_psc + 1'b1;
      end
      S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (w_tens) begin
          w_seg_nxt = f_seg_code({3'b000, w_tens}) ^ c_seg_inv;
          w_an_nxt  = 2'b10 ^ c_an_inv;
        end
`else
        w_seg_nxt = f_seg_code({3'b000, w_tens}) ^ c_seg_inv;
        w_an_nxt  = 2'b10 ^ c_an_inv;
`endif
        if (r_psc == c_psc_last) w_state_nxt = S_LOAD;
        else                     w_psc_nxt   = r_psc + 1'b1;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_psc   <= '0;
      r_snap  <= 4'd0;
      r_seg   <= c_seg_inv;
      r_an    <= c_an_inv;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_psc   <= w_psc_nxt;
      if (r_state == S_LOAD) r_snap <= count_in;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_fd;

endmodule
`default_nettype wire
